instruction_fetch: RTL and testbench

- Fetch stage of the 5-stage pipeline. Owns the PC and talks to instruction memory over a req/ready handshake.
- Drives the IF/ID register inputs (next PC and instruction) with a valid flag and a NOP bubble on flush.
- Honours decode-stage stall and branch/jump redirect from later stages.
- Writer side of the IF/ID interface: its outputs connect straight to nextPcIN/instruccionIN.

---
 rtl/instruction_fetch.sv | 155 +++++++++++++++
 tb/tb_instruction_fetch.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch stage of the 5-stage pipeline.
// Owns the PC, issues requests to instruction memory over a req/ready
// handshake and writes the IF/ID register (next PC + instruction + valid).
// Handles decode stalls through a one-entry hold buffer, and handles
// branch/jump redirects by flushing IF/ID and dropping any stale fetch.
//
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   stallIN            decode cannot accept; IF/ID outputs hold
//   branchTakenIN      one-cycle redirect pulse (highest priority after reset)
//   branchTargetIN     redirect address, low two bits forced to zero
//   imemReqOUT         instruction memory request
//   imemAddrOUT        fetch address
//   imemReadyIN        memory returns imemDataIN this cycle
//   imemDataIN         instruction word
//   nextPcOUT          registered address of fetched instruction + 4
//   instruccionOUT     registered instruction (NOP during bubbles)
//   validOUT           instruccionOUT holds a real instruction
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stallIN,
  input  logic        branchTakenIN,
  input  logic [31:0] branchTargetIN,
  output logic        imemReqOUT,
  output logic [31:0] imemAddrOUT,
  input  logic        imemReadyIN,
  input  logic [31:0] imemDataIN,
  output logic [31:0] nextPcOUT,
  output logic [31:0] instruccionOUT,
  output logic        validOUT
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HOLD = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] drop_addr_reg, drop_addr_next;
  logic [31:0] buf_instr_reg, buf_instr_next;
  logic [31:0] buf_pc_reg, buf_pc_next;
  logic [31:0] next_pc_reg, next_pc_next;
  logic [31:0] instr_reg, instr_next;
  logic        valid_reg, valid_next;
  logic [31:0] pc_plus4;

  // Wraps modulo 2^32 naturally.
  assign pc_plus4 = pc_reg + 32'd4;

  // While dropping, the outstanding request keeps its original address even
  // though pc has already moved to the redirect target.
  assign imemAddrOUT    = (state_reg == S_DROP) ? drop_addr_reg : pc_reg;
  assign imemReqOUT     = !reset && ((state_reg == S_REQ) || (state_reg == S_DROP));
  assign nextPcOUT      = next_pc_reg;
  assign instruccionOUT = instr_reg;
  assign validOUT       = valid_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_REQ;
      pc_reg        <= RESET_PC;
      drop_addr_reg <= 32'd0;
      buf_instr_reg <= NOP;
      buf_pc_reg    <= 32'd0;
      next_pc_reg   <= 32'd0;
      instr_reg     <= NOP;
      valid_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      drop_addr_reg <= drop_addr_next;
      buf_instr_reg <= buf_instr_next;
      buf_pc_reg    <= buf_pc_next;
      next_pc_reg   <= next_pc_next;
      instr_reg     <= instr_next;
      valid_reg     <= valid_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    drop_addr_next = drop_addr_reg;
    buf_instr_next = buf_instr_reg;
    buf_pc_next    = buf_pc_reg;
    next_pc_next   = next_pc_reg;
    instr_next     = instr_reg;
    valid_next     = valid_reg;

    if (branchTakenIN) begin
      // Redirect wins over stall: flush IF/ID, retarget pc.
      pc_next    = branchTargetIN & ~32'd3;
      instr_next = NOP;
      valid_next = 1'b0;
      case (state_reg)
        S_REQ: begin
          if (!imemReadyIN) begin
            state_next     = S_DROP;
            drop_addr_next = pc_reg;
          end
        end
        // A stale request completing in the redirect cycle is finished;
        // otherwise it is still outstanding and must be dropped later.
        S_DROP:  state_next = imemReadyIN ? S_REQ : S_DROP;
        S_HOLD:  state_next = S_REQ;
        default: state_next = S_REQ;
      endcase
    end else begin
      case (state_reg)
        S_REQ: begin
          if (imemReadyIN) begin
            pc_next = pc_plus4;
            if (stallIN) begin
              buf_instr_next = imemDataIN;
              buf_pc_next    = pc_plus4;
              state_next     = S_HOLD;
            end else begin
              next_pc_next = pc_plus4;
              instr_next   = imemDataIN;
              valid_next   = 1'b1;
            end
          end else if (!stallIN) begin
            instr_next = NOP;
            valid_next = 1'b0;
          end
        end
        S_HOLD: begin
          if (!stallIN) begin
            next_pc_next = buf_pc_reg;
            instr_next   = buf_instr_reg;
            valid_next   = 1'b1;
            state_next   = S_REQ;
          end
        end
        S_DROP: begin
          if (!stallIN) begin
            instr_next = NOP;
            valid_next = 1'b0;
          end
          if (imemReadyIN) begin
            state_next = S_REQ;
          end
        end
        default: state_next = S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized scoreboard bench for instruction_fetch.
// The reference model follows the program-order fetch stream: each accepted,
// non-stale memory transfer yields one expected (pc+4, mem[pc]) entry; a
// redirect discards every entry not yet taken by decode. The monitor pops an
// entry whenever decode consumes a valid IF/ID word (valid, no stall, no
// redirect, no reset).
module tb_instruction_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset, stall, branch, ready;
  logic [31:0] target, data, junk;
  logic        req, valid;
  logic [31:0] addr, next_pc, instr;

  int checks = 0;
  int errors = 0;
  int consumed = 0;

  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_instr_q[$];

  always #5 clk = ~clk;

  instruction_fetch #(.RESET_PC(RESET_PC), .NOP(NOP)) dut (
    .clk(clk),
    .reset(reset),
    .stallIN(stall),
    .branchTakenIN(branch),
    .branchTargetIN(target),
    .imemReqOUT(req),
    .imemAddrOUT(addr),
    .imemReadyIN(ready),
    .imemDataIN(data),
    .nextPcOUT(next_pc),
    .instruccionOUT(instr),
    .validOUT(valid)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Memory returns junk when not ready so stray captures are visible.
  always_comb data = ready ? mem_word(addr) : junk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples mid-cycle, where the inputs for the coming edge and the
  // current IF/ID contents are both stable.
  initial begin
    bit prev_reset;
    bit prev_branch;
    logic [31:0] e_pc, e_instr;
    prev_reset  = 1'b0;
    prev_branch = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_reset) begin
        check("reset_valid", {31'd0, valid}, 32'd0);
        check("reset_instr", instr, NOP);
        check("reset_nextpc", next_pc, 32'd0);
        check("reset_addr", addr, RESET_PC);
      end else if (prev_branch) begin
        check("flush_valid", {31'd0, valid}, 32'd0);
        check("flush_instr", instr, NOP);
      end
      if (!valid) check("bubble_is_nop", instr, NOP);
      if (reset) check("req_in_reset", {31'd0, req}, 32'd0);
      if (valid && !stall && !branch && !reset) begin
        if (exp_pc_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_instr: got pc+4=%h instr=%h expected none", next_pc, instr);
        end else begin
          e_pc    = exp_pc_q.pop_front();
          e_instr = exp_instr_q.pop_front();
          check("deliver_nextpc", next_pc, e_pc);
          check("deliver_instr", instr, e_instr);
          consumed++;
          $display("txn %0d: nextPc=%h instr=%h (exp %h/%h)", consumed, next_pc, instr, e_pc, e_instr);
        end
      end
      prev_reset  = reset;
      prev_branch = branch;
    end
  end

  // Reference model: runs just after the monitor in the same half cycle.
  initial begin
    logic [31:0] mpc;
    logic [31:0] stale_addr;
    bit stale;
    mpc        = RESET_PC;
    stale_addr = 32'd0;
    stale      = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        exp_pc_q.delete();
        exp_instr_q.delete();
        mpc   = RESET_PC;
        stale = 1'b0;
      end else begin
        if (req) begin
          if (stale) check("drop_addr_stable", addr, stale_addr);
          else       check("fetch_addr", addr, mpc);
        end
        if (branch) begin
          exp_pc_q.delete();
          exp_instr_q.delete();
          if (req && !ready) begin
            if (!stale) stale_addr = mpc;
            stale = 1'b1;
          end else begin
            stale = 1'b0;
          end
          mpc = target & ~32'd3;
        end else if (req && ready) begin
          if (stale) begin
            stale = 1'b0;
          end else begin
            exp_pc_q.push_back(mpc + 32'd4);
            exp_instr_q.push_back(mem_word(mpc));
            mpc = mpc + 32'd4;
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    reset  = 1'b1;
    stall  = 1'b0;
    branch = 1'b0;
    ready  = 1'b0;
    target = 32'd0;
    junk   = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    ready = 1'b1;
    // Zero-wait streaming warm-up.
    repeat (12) @(posedge clk);
    // Redirect to the top of the address space to exercise pc wraparound.
    #2;
    branch = 1'b1;
    target = 32'hFFFF_FFF7;
    @(posedge clk);
    #2;
    branch = 1'b0;
    repeat (6) @(posedge clk);
    for (int c = 0; c < 2000; c++) begin
      #2;
      reset  = ($urandom_range(0, 399) == 0);
      ready  = ($urandom_range(0, 99) < 65);
      stall  = ($urandom_range(0, 99) < (stall ? 60 : 15));
      branch = ($urandom_range(0, 99) < 8);
      if ($urandom_range(0, 3) == 0) target = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else                           target = 32'($urandom_range(0, 4095));
      junk = $urandom;
      @(posedge clk);
    end
    #2;
    reset  = 1'b0;
    branch = 1'b0;
    stall  = 1'b0;
    ready  = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    checks++;
    if (consumed < 200) begin
      errors++;
      $display("FAIL progress: got %0d delivered expected at least 200", consumed);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
